bp_param: RTL
=============

BP_PARAM -- requirements
Module: bp_param

Interface
REQ-001 Parameter LANES, 8, number of lanes; legal range 2..16; LW = clog2(LANES) SHALL be the lane-index width.
REQ-002 Parameter STEPS, 64, rows per pattern and outputs per pattern; legal range 2..256.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 in_valid  input  1  high for exactly STEPS consecutive cycles per pattern.
REQ-006 guy  input  LW  start lane; sampled on the first in_valid beat only.
REQ-007 in_row  input  2*LANES  one row per beat; lane i = bits [2i+1:2i]; 0 road, 1 low obstacle, 2 high obstacle, 3 wall.
REQ-008 out_valid  output  1  high for exactly STEPS consecutive cycles per pattern.
REQ-009 out  output  2  move per step: 0 stay, 1 right (lane+1), 2 left (lane-1), 3 jump.

Function
REQ-010 The FSM SHALL have states IDLE, LOAD, SCAN and OUT: IDLE->LOAD on in_valid; LOAD->SCAN after the STEPS-th beat; SCAN->OUT after STEPS cycles; OUT->IDLE after STEPS cycles.
REQ-011 A row SHALL be an obstacle row iff any lane equals 3; its gap SHALL be the lowest-index lane not equal to 3, and its type the value in that lane; an all-3 row SHALL use gap 0, type 0.
REQ-012 A row without any 3 SHALL be an empty row, irrespective of its 1/2 values.
REQ-013 LOAD SHALL store, per row, {obstacle flag, gap, type} into a STEPS-deep buffer, in row order.
REQ-014 SCAN SHALL walk the buffer from row STEPS-1 down to 0 and record per row k the target: row k itself if obstacle, else row k+1's target, else "none" for trailing empty rows.
REQ-015 In OUT, with current lane p (initially guy) and step k's target {row t, gap g, type y}: p!=g -> out = 1 if g>p, 2 if g<p; p==g and t==k and y==1 -> out 3; otherwise out 0; target "none" -> out 0.
REQ-016 p SHALL update after each move (1: +1, 2: -1, 0/3: unchanged) and SHALL saturate at 0 and LANES-1.
REQ-017 The first out_valid cycle SHALL occur exactly STEPS+1 cycles after the cycle holding the last in_valid beat.
REQ-018 out SHALL be 0 whenever out_valid is 0.
REQ-019 in_valid asserted in SCAN or OUT SHALL be ignored, with no effect on outputs or stored rows.
REQ-020 A new pattern SHALL be accepted in the first cycle after out_valid falls.
REQ-021 The buffer SHALL need no reset; no stale row SHALL influence a following pattern.

Reset
REQ-022 rst_n low SHALL immediately force the FSM to IDLE, out_valid to 0, out to 0, p and all counters to 0, and err to 0 when present.
REQ-023 A reset in LOAD, SCAN or OUT SHALL abort the pattern; the next in_valid SHALL start a fresh pattern.

Configuration
REQ-024 With macro BP_PARAM_ERR_EN defined, the block SHALL add output err (1 bit), registered alongside out.
REQ-025 err SHALL be 1 for step k iff row k is an obstacle row and either the lane after step k differs from g, or y!=0 and the lane before step k differs from g; otherwise err SHALL be 0. Moves SHALL be unaffected by err.
REQ-026 Without BP_PARAM_ERR_EN, the port err and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (LANES=8, STEPS=64)
REQ-027 Reset during OUT -> out_valid=0 and out=0 immediately; a new pattern afterwards produces correct results.
REQ-028 guy=3, all 64 rows empty -> 64 cycles of out=0, starting 65 cycles after the last beat.
REQ-029 guy=0; row 5 has walls except lane 4 (value 0) -> steps 0-3 out=1, steps 4-63 out=0.
REQ-030 guy=7; row 2 has walls except lane 7 (value 1); row 6 has walls except lane 5 (value 2) -> step 2 out=3, steps 3-4 out=2, all other steps out=0.
REQ-031 in_valid pulsed for 3 cycles during OUT -> output sequence unchanged; the next full pattern is accepted immediately after out_valid falls.
REQ-032 BP_PARAM_ERR_EN defined; guy=0; row 1 has walls except lane 7 (value 0) -> err=1 only at step 1; out=1 for steps 0-6.

Source files
------------

// File: rtl/bp_param_if.sv
// Handshake bundle for bp_param: row input stream and move output stream.
// Carries the err output when BP_PARAM_ERR_EN is defined.
interface bp_param_if #(
  parameter int LANES = 8
);
  localparam int LW = $clog2(LANES);

  logic                 in_valid;
  logic [LW-1:0]        guy;
  logic [2*LANES-1:0]   in_row;
  logic                 out_valid;
  logic [1:0]           out;
`ifdef BP_PARAM_ERR_EN
  logic                 err;

  modport master (output in_valid, guy, in_row, input out_valid, out, err);
  modport slave  (input in_valid, guy, in_row, output out_valid, out, err);
`else
  modport master (output in_valid, guy, in_row, input out_valid, out);
  modport slave  (input in_valid, guy, in_row, output out_valid, out);
`endif
endinterface

// File: rtl/bp_param.sv
// Lane-runner planner: loads STEPS rows, back-scans obstacle targets, then emits one move per step.
// Optional err output is enabled by defining BP_PARAM_ERR_EN.
module bp_param #(
  parameter int LANES = 8,
  parameter int STEPS = 64
) (
  input logic       clk,
  input logic       rst_n,
  bp_param_if.slave bus
);
  localparam int LW = $clog2(LANES);
  localparam int CW = $clog2(STEPS);
  localparam int RW = LW + 3;

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, OUT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [LW-1:0] p;
  logic          carry_vld;
  logic [LW-1:0] carry_gap;
  logic [1:0]    carry_typ;

  // Row store {obstacle, gap, type}; target store {valid, self, gap, type}
  logic [RW-1:0] row_buf [STEPS];
  logic [RW:0]   tgt_buf [STEPS];

  function automatic logic [1:0] move_of(input logic vld, input logic self,
                                         input logic [LW-1:0] g, input logic [1:0] y,
                                         input logic [LW-1:0] pos);
    if (!vld)          return 2'd0;
    if (pos != g)      return (g > pos) ? 2'd1 : 2'd2;
    if (self && y == 2'd1) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [LW-1:0] next_lane(input logic [LW-1:0] pos, input logic [1:0] mv);
    case (mv)
      2'd1:    return (pos == LW'(LANES - 1)) ? pos : pos + 1'b1;
      2'd2:    return (pos == '0) ? pos : pos - 1'b1;
      default: return pos;
    endcase
  endfunction

  // Incoming row decode: lowest non-wall lane is the gap
  logic          row_obs;
  logic [LW-1:0] row_gap;
  logic [1:0]    row_typ;

  always_comb begin
    row_obs = 1'b0;
    row_gap = '0;
    row_typ = 2'd0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (bus.in_row[2*i +: 2] == 2'd3) begin
        row_obs = 1'b1;
      end else begin
        row_gap = LW'(i);
        row_typ = bus.in_row[2*i +: 2];
      end
    end
  end

  logic          last;
  logic          load_en;
  logic [CW-1:0] scan_idx;
  logic [CW-1:0] cnt_nxt;
  logic          s_obs;
  logic [LW-1:0] s_gap;
  logic [1:0]    s_typ;
  logic [RW:0]   scan_tgt;
  logic [RW:0]   step_tgt;
  logic          t_vld, t_self;
  logic [LW-1:0] t_gap;
  logic [1:0]    t_typ;
  logic [1:0]    mv;
  logic [LW-1:0] np;
  logic          step_fire;
  logic          out_end;

  assign last     = (cnt == CW'(STEPS - 1));
  assign load_en  = bus.in_valid && (state == IDLE || state == LOAD);
  assign scan_idx = CW'(STEPS - 1) - cnt;
  assign cnt_nxt  = cnt + 1'b1;
  assign {s_obs, s_gap, s_typ} = row_buf[scan_idx];
  assign scan_tgt = s_obs ? {1'b1, 1'b1, s_gap, s_typ} : {carry_vld, 1'b0, carry_gap, carry_typ};

  // Step 0 is taken straight from the final scan cycle so OUT starts without a bubble
  assign step_tgt  = (state == SCAN) ? scan_tgt : tgt_buf[cnt_nxt];
  assign {t_vld, t_self, t_gap, t_typ} = step_tgt;
  assign mv        = move_of(t_vld, t_self, t_gap, t_typ, p);
  assign np        = next_lane(p, mv);
  assign step_fire = (state == SCAN && last) || (state == OUT && !last);
  assign out_end   = (state == OUT) && last;

  always_ff @(posedge clk) begin
    if (load_en) row_buf[cnt] <= {row_obs, row_gap, row_typ};
    if (state == SCAN) tgt_buf[scan_idx] <= scan_tgt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      p             <= '0;
      carry_vld     <= 1'b0;
      carry_gap     <= '0;
      carry_typ     <= 2'd0;
      bus.out_valid <= 1'b0;
      bus.out       <= 2'd0;
    end else begin
      if (step_fire) begin
        bus.out_valid <= 1'b1;
        bus.out       <= mv;
        p             <= np;
      end
      case (state)
        IDLE: if (bus.in_valid) begin
          p     <= bus.guy;
          cnt   <= CW'(1);
          state <= LOAD;
        end
        LOAD: if (bus.in_valid) begin
          if (last) begin
            cnt       <= '0;
            carry_vld <= 1'b0;
            state     <= SCAN;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        SCAN: begin
          if (s_obs) begin
            carry_vld <= 1'b1;
            carry_gap <= s_gap;
            carry_typ <= s_typ;
          end
          if (last) begin
            cnt   <= '0;
            state <= OUT;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        OUT: if (last) begin
          cnt           <= '0;
          bus.out_valid <= 1'b0;
          bus.out       <= 2'd0;
          state         <= IDLE;
        end else begin
          cnt <= cnt_nxt;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BP_PARAM_ERR_EN
  logic step_err;
  assign step_err = t_self && ((np != t_gap) || (t_typ != 2'd0 && p != t_gap));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         bus.err <= 1'b0;
    else if (step_fire) bus.err <= step_err;
    else if (out_end)   bus.err <= 1'b0;
  end
`endif
endmodule
